// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store per handshake,
// waits a fixed latency, commits at the edge entering RESP and pulses a response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            lat_write, lat_err;
  logic [AW-1:0]   lat_idx;
  logic [63:0]     lat_wdata;
  logic [63:0]     rdata_q;
  logic            err_q;
  logic            accept, in_err, commit;
  logic            c_write, c_err;
  logic [AW-1:0]   c_idx;
  logic [63:0]     c_wdata;

  // No reset on the array: contents rely on zero power-up and survive reset.
  logic [63:0]     mem [DEPTH_WORDS];

  assign req_ready  = (state == IDLE || state == RESP) && !reset;
  assign accept     = req_valid && req_ready;
  assign in_err     = (req_addr[2:0] != 3'b000) || (|req_addr[63:AW+3]);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, RESP: begin
        if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
        else        state_next = IDLE;
      end
      WAIT:    if (cnt == '0) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // With a single-cycle latency the commit edge is the accept edge itself,
  // so the access is taken straight from the request inputs.
  assign commit  = (state_next == RESP) && !reset;
  assign c_write = (LATENCY == 1) ? req_write          : lat_write;
  assign c_err   = (LATENCY == 1) ? in_err             : lat_err;
  assign c_idx   = (LATENCY == 1) ? req_addr[3 +: AW]  : lat_idx;
  assign c_wdata = (LATENCY == 1) ? req_wdata          : lat_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= CW'(LOAD);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CW'(1);
      err_q   <= commit && c_err;
      rdata_q <= (commit && !c_write && !c_err) ? mem[c_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= req_write;
      lat_err   <= in_err;
      lat_idx   <= req_addr[3 +: AW];
      lat_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err)
      mem[c_idx] <= c_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked every
// cycle against an edge-counting transaction model, plus directed literal checks.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        rv  [2];
  logic        rw  [2];
  logic [63:0] ra  [2];
  logic [63:0] rd  [2];
  logic        rdy [2];
  logic        vld [2];
  logic        err [2];
  logic        bsy [2];
  logic [63:0] rdat[2];

  int compared   = 0;
  int mismatched = 0;

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(3)) dutA (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rd[0]), .req_ready(rdy[0]), .resp_valid(vld[0]),
    .resp_rdata(rdat[0]), .resp_err(err[0]), .busy(bsy[0]));

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dutB (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rd[1]), .req_ready(rdy[1]), .resp_valid(vld[1]),
    .resp_rdata(rdat[1]), .resp_err(err[1]), .busy(bsy[1]));

  // Transaction model: at most one request pending, committing LATENCY-1 edges
  // after its accept edge; the expected response is shown in the following cycle.
  int          edgeNum = 0;
  logic        pendV   [2];
  int          pendEdge[2];
  logic        pendW   [2];
  logic        pendE   [2];
  logic [63:0] pendA   [2];
  logic [63:0] pendD   [2];
  logic        expV    [2];
  logic        expE    [2];
  logic [63:0] expD    [2];
  logic        acc     [2];
  logic [63:0] mdl     [2][128];

  function automatic int latOf(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic logic isBad(input logic [63:0] a);
    return (a % 8 != 0) || (a >= 64'd1024);
  endfunction

  task automatic commitModel(input int i, input logic w, input logic [63:0] a,
                             input logic [63:0] d, input logic e);
    expV[i] = 1'b1;
    expE[i] = e;
    expD[i] = '0;
    if (!e) begin
      if (w) mdl[i][int'(a / 8)] = d;
      else   expD[i] = mdl[i][int'(a / 8)];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pendV[i] = 0; pendEdge[i] = 0; expV[i] = 0; expE[i] = 0; expD[i] = '0; acc[i] = 0;
      pendW[i] = 0; pendE[i] = 0; pendA[i] = '0; pendD[i] = '0;
      for (int j = 0; j < 128; j++) mdl[i][j] = '0;
    end
  end

  always @(posedge clk) begin
    logic readyPre;
    edgeNum++;
    for (int i = 0; i < 2; i++) begin
      readyPre = !rst[i] && !pendV[i];
      acc[i]   = 1'b0;
      expV[i]  = 1'b0;
      expE[i]  = 1'b0;
      expD[i]  = '0;
      if (rst[i]) begin
        pendV[i] = 1'b0;
      end else begin
        if (pendV[i] && pendEdge[i] == edgeNum) begin
          commitModel(i, pendW[i], pendA[i], pendD[i], pendE[i]);
          pendV[i] = 1'b0;
        end
        if (rv[i] && readyPre) begin
          acc[i] = 1'b1;
          if (latOf(i) == 1) begin
            commitModel(i, rw[i], ra[i], rd[i], isBad(ra[i]));
          end else begin
            pendV[i] = 1'b1; pendEdge[i] = edgeNum + latOf(i) - 1;
            pendW[i] = rw[i]; pendA[i] = ra[i]; pendD[i] = rd[i]; pendE[i] = isBad(ra[i]);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Continuous per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "A" : "B";
      checkOutput({p, ".req_ready"},  64'(rdy[i]),  64'(!rst[i] && !pendV[i]));
      checkOutput({p, ".resp_valid"}, 64'(vld[i]),  64'(expV[i]));
      checkOutput({p, ".resp_rdata"}, rdat[i],      expD[i]);
      checkOutput({p, ".busy"},       64'(bsy[i]),  64'(pendV[i] || expV[i]));
      if (expV[i]) checkOutput({p, ".resp_err"}, 64'(err[i]), 64'(expE[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one request, waits for its accept and then for its response cycle;
  // returns at the negedge inside the response cycle.
  task automatic applyStimulus(input int i, input logic w, input logic [63:0] a,
                               input logic [63:0] d, output int lat, output int busyCnt);
    bit got;
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rd[i] = d;
    lat = 0; busyCnt = 0; got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      got = acc[i];
    end
    if (!got) begin
      compared++; mismatched++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept within 20 cycles");
    end
    rv[i] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      lat++;
      if (bsy[i]) busyCnt++;
      if (vld[i]) break;
    end
  endtask

  function automatic logic [63:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 1023)) | 64'($urandom_range(1, 7));
      2:       return 64'd1024 + 64'($urandom_range(0, 100)) * 8;
      default: return 64'($urandom_range(0, 15)) * 8;
    endcase
  endfunction

  initial begin
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    repeat (2) tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    checkOutput("reset.ready", 64'(rdy[0]), 64'd1);
    checkOutput("reset.valid", 64'(vld[0]), 64'd0);
    checkOutput("reset.busy",  64'(bsy[0]), 64'd0);
    checkOutput("reset.rdata", rdat[0],     64'd0);
    checkOutput("reset.err",   64'(err[0]), 64'd0);

    applyStimulus(0, 1'b1, 64'h10, 64'hDEADBEEF_00000001, lat, bc);
    checkOutput("t1.latency", 64'(lat), 64'd3);
    checkOutput("t1.busy_cycles", 64'(bc), 64'd3);
    checkOutput("t1.err", 64'(err[0]), 64'd0);
    checkOutput("t1.rdata", rdat[0], 64'd0);

    applyStimulus(0, 1'b0, 64'h10, 64'h0, lat, bc);
    checkOutput("t2.load10", rdat[0], 64'hDEADBEEF_00000001);
    checkOutput("t2.err", 64'(err[0]), 64'd0);
    applyStimulus(0, 1'b0, 64'h08, 64'h0, lat, bc);
    checkOutput("t2.load08", rdat[0], 64'd0);

    applyStimulus(0, 1'b1, 64'h18, 64'h55, lat, bc);
    applyStimulus(0, 1'b0, 64'h18, 64'h0, lat, bc);
    checkOutput("t3.latency", 64'(lat), 64'd3);
    checkOutput("t3.load18", rdat[0], 64'h55);

    applyStimulus(0, 1'b1, 64'h13, 64'h77, lat, bc);
    checkOutput("t4.mis_err", 64'(err[0]), 64'd1);
    checkOutput("t4.mis_rdata", rdat[0], 64'd0);
    applyStimulus(0, 1'b1, 64'h400, 64'h77, lat, bc);
    checkOutput("t4.oor_err", 64'(err[0]), 64'd1);
    checkOutput("t4.oor_rdata", rdat[0], 64'd0);
    applyStimulus(0, 1'b0, 64'h10, 64'h0, lat, bc);
    checkOutput("t4.load10", rdat[0], 64'hDEADBEEF_00000001);

    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h20; rd[0] = 64'hAA;
    tick();
    rv[0] = 1'b0; rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checkOutput("t5.valid", 64'(vld[0]), 64'd0);
      checkOutput("t5.busy",  64'(bsy[0]), 64'd0);
      checkOutput("t5.rdata", rdat[0],     64'd0);
    end
    applyStimulus(0, 1'b0, 64'h20, 64'h0, lat, bc);
    checkOutput("t5.load20", rdat[0], 64'd0);

    for (int j = 0; j < 4; j++) begin
      rv[1] = 1'b1; rw[1] = (j % 2 == 0); ra[1] = 64'h30;
      rd[1] = (j < 2) ? 64'h1111 : 64'h2222;
      tick();
      @(negedge clk);
      checkOutput("t6.ready", 64'(rdy[1]), 64'd1);
      checkOutput("t6.valid", 64'(vld[1]), 64'd1);
      checkOutput("t6.rdata", rdat[1], (j == 1) ? 64'h1111 : (j == 3) ? 64'h2222 : 64'h0);
    end
    rv[1] = 1'b0;

    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 49) == 0);
        rv[i]  = ($urandom_range(0, 2) != 0);
        rw[i]  = 1'($urandom_range(0, 1));
        ra[i]  = randAddr();
        rd[i]  = {$urandom, $urandom};
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; rv[i] = 1'b0;
    end
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
